// File: rtl/eg4_board_io.sv
// eg4_board_io: board I/O controller for the EG4S20 board family.
// Button path: two-flop synchroniser, optional pin inversion, a strobe-counted
// debounce per button, and one-cycle press/release events.
// LED path: per-channel off/direct/blink/PWM modes, with pin polarity applied
// in a final output register. The PWM and blink counters are shared by all channels.

module eg4_board_io #(
   parameter int BTN_NUM  = 1,
   parameter bit BTN_INV  = 1'b0,
   parameter int DEB_MS   = 16,
   parameter int LED_NUM  = 3,
   parameter bit LED_INV  = 1'b1,
   parameter int PWM_BITS = 4,
   parameter int BLINK_MS = 250
) (
   input  logic                         sys_clk_p,
   input  logic                         sys_rst,
   input  logic                         ena_us,
   input  logic                         ena_ms,
   input  logic [BTN_NUM-1:0]           btn_in,
   output logic [BTN_NUM-1:0]           btn_out,
   output logic [BTN_NUM-1:0]           btn_prs,
   output logic [BTN_NUM-1:0]           btn_rel,
   input  logic [LED_NUM-1:0]           led_src,
   input  logic [2*LED_NUM-1:0]         led_mode,
   input  logic [PWM_BITS*LED_NUM-1:0]  led_duty,
   output logic [LED_NUM-1:0]           led_pin
);

   localparam logic [7:0] DEB_LAST   = 8'(DEB_MS - 1);
   localparam logic [9:0] BLINK_LAST = 10'(BLINK_MS - 1);

   localparam logic [1:0] MODE_OFF    = 2'b00;
   localparam logic [1:0] MODE_DIRECT = 2'b01;
   localparam logic [1:0] MODE_BLINK  = 2'b10;

   // ---------------------------------------------------------------- buttons

   logic [BTN_NUM-1:0] r_sync1;
   logic [BTN_NUM-1:0] r_sync2;
   logic [BTN_NUM-1:0] w_s;
   logic [BTN_NUM-1:0] r_btn_out;
   logic [BTN_NUM-1:0] r_btn_prs;
   logic [BTN_NUM-1:0] r_btn_rel;
   logic [7:0]         r_deb_cnt [BTN_NUM];

   // two-flop synchroniser for the asynchronous button pins
   always_ff @(posedge sys_clk_p or posedge sys_rst) begin
      if (sys_rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= btn_in;
         r_sync2 <= r_sync1;
      end
   end

   // Inversion happens after synchronisation, so the sync flops clear to 0 regardless of BTN_INV.
   assign w_s = r_sync2 ^ {BTN_NUM{BTN_INV}};

   // per-button debounce: count strobes while the input disagrees with the debounced level
   always_ff @(posedge sys_clk_p or posedge sys_rst) begin
      if (sys_rst) begin
         r_btn_out <= '0;
         r_btn_prs <= '0;
         r_btn_rel <= '0;
         for (int i = 0; i < BTN_NUM; i++) begin
            r_deb_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < BTN_NUM; i++) begin
            r_btn_prs[i] <= 1'b0;
            r_btn_rel[i] <= 1'b0;
            if (w_s[i] == r_btn_out[i]) begin
               // any return to agreement, including a bounce, restarts the count
               r_deb_cnt[i] <= '0;
            end else if (ena_ms) begin
               if (r_deb_cnt[i] == DEB_LAST) begin
                  r_btn_out[i] <= w_s[i];
                  r_deb_cnt[i] <= '0;
                  r_btn_prs[i] <= w_s[i];
                  r_btn_rel[i] <= ~w_s[i];
               end else begin
                  r_deb_cnt[i] <= r_deb_cnt[i] + 8'd1;
               end
            end
         end
      end
   end

   assign btn_out = r_btn_out;
   assign btn_prs = r_btn_prs;
   assign btn_rel = r_btn_rel;

   // ------------------------------------------------------------------- LEDs

   logic [PWM_BITS-1:0] r_pwm_cnt;
   logic [9:0]          r_blink_cnt;
   logic                r_blink_ph;
   logic [LED_NUM-1:0]  w_led_l;
   logic [LED_NUM-1:0]  r_led_pin;

   // Shared PWM counter. It advances on each microsecond strobe and wraps naturally.
   always_ff @(posedge sys_clk_p or posedge sys_rst) begin
      if (sys_rst) begin
         r_pwm_cnt <= '0;
      end else if (ena_us) begin
         r_pwm_cnt <= r_pwm_cnt + 1'b1;
      end
   end

   // Shared blink counter. The phase toggles once per blink half-period.
   always_ff @(posedge sys_clk_p or posedge sys_rst) begin
      if (sys_rst) begin
         r_blink_cnt <= '0;
         r_blink_ph  <= 1'b0;
      end else if (ena_ms) begin
         if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= ~r_blink_ph;
         end else begin
            r_blink_cnt <= r_blink_cnt + 10'd1;
         end
      end
   end

   // Per-channel logical LED value from mode, request, blink phase and PWM compare.
   // With the strict less-than, duty 0 is never lit and full-scale duty misses one slot.
   always_comb begin
      w_led_l = '0;
      for (int i = 0; i < LED_NUM; i++) begin
         case (led_mode[2*i +: 2])
            MODE_OFF:    w_led_l[i] = 1'b0;
            MODE_DIRECT: w_led_l[i] = led_src[i];
            MODE_BLINK:  w_led_l[i] = led_src[i] & r_blink_ph;
            default:     w_led_l[i] = led_src[i] &
                                      (r_pwm_cnt < led_duty[PWM_BITS*i +: PWM_BITS]);
         endcase
      end
   end

   // Registered pin drive with polarity applied. Reset leaves every LED dark.
   always_ff @(posedge sys_clk_p or posedge sys_rst) begin
      if (sys_rst) begin
         r_led_pin <= {LED_NUM{LED_INV}};
      end else begin
         r_led_pin <= w_led_l ^ {LED_NUM{LED_INV}};
      end
   end

   assign led_pin = r_led_pin;

endmodule

// File: tb/tb_eg4_board_io.sv
// Directed bench for eg4_board_io. It exercises the debounce, bounce, reset and LED modes,
// plus PWM counts and coincident events.

module tb_eg4_board_io;

   logic        sys_clk_p = 1'b0;
   logic        sys_rst   = 1'b0;
   logic        ena_us    = 1'b0;
   logic        ena_ms    = 1'b0;
   logic [1:0]  btn_in    = '0;
   logic [1:0]  btn_out;
   logic [1:0]  btn_prs;
   logic [1:0]  btn_rel;
   logic [2:0]  led_src   = '0;
   logic [5:0]  led_mode  = '0;
   logic [11:0] led_duty  = '0;
   logic [2:0]  led_pin;

   int n_chk = 0;
   int n_err = 0;

   eg4_board_io #(
      .BTN_NUM(2), .BTN_INV(1'b0), .DEB_MS(4), .LED_NUM(3),
      .LED_INV(1'b1), .PWM_BITS(4), .BLINK_MS(2)
   ) dut (
      .sys_clk_p(sys_clk_p), .sys_rst(sys_rst), .ena_us(ena_us), .ena_ms(ena_ms),
      .btn_in(btn_in), .btn_out(btn_out), .btn_prs(btn_prs), .btn_rel(btn_rel),
      .led_src(led_src), .led_mode(led_mode), .led_duty(led_duty), .led_pin(led_pin)
   );

   always #5 sys_clk_p = ~sys_clk_p;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk_p);
      #1;
   endtask

   task automatic ms_pulse();
      ena_ms = 1'b1;
      tick();
      ena_ms = 1'b0;
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      tick();
      tick();
      sys_rst = 1'b0;
      tick();
   endtask

   // expected pins for PWM test: ch0 duty 4, ch1 duty 0, ch2 duty 15, active-low
   function automatic logic [2:0] pwm_pin(input int m);
      logic [2:0] l;
      l = {(m < 15), 1'b0, (m < 4)};
      return ~l;
   endfunction

   initial begin
      int m;
      int lit0, lit1, lit2;

      // asynchronous reset, checked before any clock edge
      #1 sys_rst = 1'b1;
      #2;
      chk("rst_async_pin", 32'(led_pin), 32'h7);
      chk("rst_async_out", 32'(btn_out), 32'h0);
      chk("rst_async_prs", 32'({btn_prs, btn_rel}), 32'h0);
      tick();
      sys_rst = 1'b0;
      tick();
      chk("rst_hold_pin", 32'(led_pin), 32'h7);

      // clean press on button 0
      btn_in = 2'b01;
      tick(); tick();
      for (int k = 0; k < 3; k++) begin
         ms_pulse();
         chk("press_wait", 32'(btn_out), 32'h0);
         tick();
      end
      ms_pulse();
      chk("press_out", 32'(btn_out), 32'h1);
      chk("press_prs", 32'(btn_prs), 32'h1);
      chk("press_rel0", 32'(btn_rel), 32'h0);
      tick();
      chk("press_prs_1cyc", 32'(btn_prs), 32'h0);

      // clean release
      btn_in = 2'b00;
      tick(); tick();
      for (int k = 0; k < 3; k++) begin
         ms_pulse();
         chk("rel_wait", 32'(btn_out), 32'h1);
      end
      ms_pulse();
      chk("rel_out", 32'(btn_out), 32'h0);
      chk("rel_rel", 32'(btn_rel), 32'h1);
      chk("rel_prs0", 32'(btn_prs), 32'h0);
      tick();
      chk("rel_rel_1cyc", 32'(btn_rel), 32'h0);

      // bounce: 3 strobes high, one low, then a full 4 are needed
      btn_in = 2'b01;
      tick(); tick();
      for (int k = 0; k < 3; k++) ms_pulse();
      btn_in = 2'b00;
      tick(); tick();
      ms_pulse();
      chk("bounce_no_evt", 32'({btn_out, btn_prs}), 32'h0);
      btn_in = 2'b01;
      tick(); tick();
      for (int k = 0; k < 3; k++) begin
         ms_pulse();
         chk("bounce_wait", 32'({btn_out, btn_prs}), 32'h0);
      end
      ms_pulse();
      chk("bounce_prs", 32'({btn_out, btn_prs}), 32'h5);

      // reset mid-count on a release clears the count
      btn_in = 2'b00;
      tick(); tick();
      for (int k = 0; k < 3; k++) ms_pulse();
      btn_in = 2'b01;
      sys_rst = 1'b1;
      #1;
      chk("midrst_out", 32'(btn_out), 32'h0);
      tick(); tick();
      sys_rst = 1'b0;
      tick(); tick();
      for (int k = 0; k < 3; k++) begin
         ms_pulse();
         chk("midrst_wait", 32'({btn_out, btn_prs}), 32'h0);
      end
      ms_pulse();
      chk("midrst_prs", 32'({btn_out, btn_prs}), 32'h5);
      btn_in = 2'b00;

      // LED direct and off modes
      do_reset();
      led_src  = 3'b111;
      led_mode = 6'b01_01_01;
      #1;
      chk("direct_latency", 32'(led_pin), 32'h7);
      tick();
      chk("direct_on", 32'(led_pin), 32'h0);
      led_mode = 6'b00_00_00;
      tick();
      chk("off_mode", 32'(led_pin), 32'h7);

      // blink: phase toggles every 2 strobes, pin follows one clock later
      do_reset();
      led_mode = 6'b10_10_10;
      tick();
      chk("blink_start", 32'(led_pin), 32'h7);
      for (int n = 1; n <= 8; n++) begin
         ms_pulse();
         tick();
         chk("blink", 32'(led_pin), ((n / 2) % 2) ? 32'h0 : 32'h7);
      end

      // PWM: duties 4/0/15 over two full periods
      do_reset();
      led_duty = {4'd15, 4'd0, 4'd4};
      led_mode = 6'b11_11_11;
      tick();
      m = 0;
      chk("pwm_init", 32'(led_pin), 32'(pwm_pin(m)));
      lit0 = 0; lit1 = 0; lit2 = 0;
      for (int k = 0; k < 32; k++) begin
         ena_us = 1'b1;
         tick();
         ena_us = 1'b0;
         chk("pwm_hold", 32'(led_pin), 32'(pwm_pin(m)));
         m = (m + 1) % 16;
         tick();
         chk("pwm_upd", 32'(led_pin), 32'(pwm_pin(m)));
         if (!led_pin[0]) lit0++;
         if (!led_pin[1]) lit1++;
         if (!led_pin[2]) lit2++;
      end
      chk("pwm_lit_d4", 32'(lit0), 32'd8);
      chk("pwm_lit_d0", 32'(lit1), 32'd0);
      chk("pwm_lit_d15", 32'(lit2), 32'd30);

      // two buttons cross on the same strobe, which also carries ena_us
      do_reset();
      led_duty = 12'h001;
      led_mode = 6'b00_00_11;
      tick();
      chk("sim_pin0", 32'(led_pin), 32'h6);
      btn_in = 2'b11;
      tick(); tick();
      for (int k = 0; k < 3; k++) ms_pulse();
      chk("sim_wait", 32'(btn_out), 32'h0);
      ena_us = 1'b1;
      ms_pulse();
      ena_us = 1'b0;
      chk("sim_prs", 32'(btn_prs), 32'h3);
      chk("sim_out", 32'(btn_out), 32'h3);
      chk("sim_pin_hold", 32'(led_pin), 32'h6);
      tick();
      chk("sim_pwm_adv", 32'(led_pin), 32'h7);
      chk("sim_prs_1cyc", 32'(btn_prs), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/eg4_board_io.md
Name: eg4_board_io

Overview:
Parametrised board I/O controller for the EG4S20 board family and its successors. It synchronises and debounces BTN_NUM push buttons and emits one-cycle press/release events. It drives LED_NUM LEDs, each in a per-channel mode: off, direct, blink or PWM dimming, with selectable pin polarity. It sits beside the CPU wrapper in the board top and replaces the fixed inverted LED assignment and raw button wiring.

Parameters:
BTN_NUM, 1, number of button inputs (1..8)
BTN_INV, 0, 1 = buttons are active-low at the pin
DEB_MS, 16, debounce time in ms strobes (1..255)
LED_NUM, 3, number of LED outputs (1..16)
LED_INV, 1, 1 = LED pins are active-low (board RGB LED)
PWM_BITS, 4, PWM counter and duty width (2..8)
BLINK_MS, 250, blink half-period in ms strobes (1..1023)

Ports:
sys_clk_p  in  1  system clock
sys_rst  in  1  reset; asynchronous, active-high
ena_us  in  1  one-cycle microsecond strobe from the CPU wrapper
ena_ms  in  1  one-cycle millisecond strobe from the CPU wrapper
btn_in  in  BTN_NUM  raw button pins, asynchronous
btn_out  out  BTN_NUM  debounced level, 1 = pressed
btn_prs  out  BTN_NUM  one-cycle pulse on debounced press
btn_rel  out  BTN_NUM  one-cycle pulse on debounced release
led_src  in  LED_NUM  logical LED request from the system (1 = lit)
led_mode  in  2*LED_NUM  per-LED mode; channel i uses bits [2i+1:2i]
led_duty  in  PWM_BITS*LED_NUM  per-LED PWM duty; channel i uses its slice
led_pin  out  LED_NUM  LED pins, polarity applied

Behaviour:
- Reset: all flops clear. btn_out=0, btn_prs=0, btn_rel=0, debounce counters=0, sync stages=0. The PWM counter, blink counter and blink phase are 0. led_pin = {LED_NUM{LED_INV}}, so all LEDs are dark. Reset acts immediately and needs no clock.

Buttons:
- Each btn_in passes through 2 synchroniser flops. It is inverted after synchronisation when BTN_INV=1, giving s[i].
- Per-button counter, width 8.
- While s[i]==btn_out[i], the counter is held at 0 every cycle.
- While s[i]!=btn_out[i], each ena_ms increments the counter.
- If the counter equals DEB_MS-1 on an ena_ms (DEB_MS consecutive strobes with a mismatch), then in that cycle: btn_out[i]<=s[i], the counter is cleared, and btn_prs[i] (new value 1) or btn_rel[i] (new value 0) is asserted for exactly one cycle.
- Any bounce back to equality before that point clears the counter, and no event is produced.
- Buttons are independent. Events on several buttons in the same cycle are all reported.

LEDs:
- Shared PWM counter, PWM_BITS wide, increments on ena_us and wraps from 2^PWM_BITS-1 to 0.
- Shared blink counter, 10 bits: on each ena_ms, if it equals BLINK_MS-1 it wraps to 0 and the blink phase toggles; otherwise it increments.
- Channel logical value L[i] by mode:
  - 00: off, L=0.
  - 01: direct, L=led_src[i].
  - 10: blink, L=led_src[i] & phase.
  - 11: PWM, L=led_src[i] & (pwm_cnt < duty[i]), unsigned compare.
- PWM duty rules: duty 0 gives constant off. Duty 2^PWM_BITS-1 gives on for (2^PWM_BITS-1)/2^PWM_BITS of the period.
- led_pin[i] is registered as L[i]^LED_INV. Latency is 1 clock from any change of mode, src, duty or counter.
- ena_us and ena_ms in the same cycle are both applied.
- A mode change takes effect next cycle and does not reset the shared counters.

Test Plan:
- Reset, then hold: all outputs 0 except led_pin = LED_INV pattern (3'b111 with defaults). No clock edge is required to reach this state (check async assert).
- Clean press with DEB_MS=4: btn_in=1 held. btn_out rises on the 4th ena_ms after sync; btn_prs is high exactly 1 cycle; btn_rel stays 0. Releasing gives btn_rel=1 for 1 cycle after 4 strobes.
- Bounce: btn_in high for 3 strobes, low for 1, then high → no event until 4 further consecutive strobes. Reset asserted mid-count clears the count, and a full DEB_MS is needed afterwards.
- Modes with LED_INV=1 and led_src=3'b111:
  - mode 01 → led_pin=0.
  - mode 00 → led_pin=1.
  - mode 10 with BLINK_MS=2 → pin toggles every 2 ena_ms.
- PWM with PWM_BITS=4:
  - duty=4 → lit on 4 of every 16 ena_us.
  - duty=0 → never lit.
  - duty=15 → lit on 15 of 16.
  - Pin updates 1 clock after the counter.
- Simultaneous events: 2 buttons crossing threshold on the same ena_ms, which also coincides with ena_us → both btn_prs bits set in the same cycle, and the PWM counter still advances.
